// File: rtl/bram_porta_req_ctrl.sv
// rtl/bram_porta_req_ctrl.sv - credit-protected request/response front-end for BRAM port A (optional stats: BRAM_PORTA_STATS_EN)
module bram_porta_req_ctrl #(
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                          clka,
    input  logic                          rsta_n,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [NB_COL-1:0]             req_we,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [NB_COL*COL_WIDTH-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         ram_addra,
    output logic [NB_COL*COL_WIDTH-1:0]   ram_dina,
    output logic [NB_COL-1:0]             ram_wea,
    output logic                          ram_ena,
    output logic                          ram_regcea,
    output logic                          ram_rsta,
    input  logic [NB_COL*COL_WIDTH-1:0]   ram_douta
`ifdef BRAM_PORTA_STATS_EN
    ,
    output logic [15:0]                   stat_rd_cnt,
    output logic [15:0]                   stat_wr_cnt,
    output logic [15:0]                   stat_stall_cnt
`endif
);

    localparam int DW = NB_COL * COL_WIDTH;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 2;

    logic                live;
    logic                s1;
    logic                s2;
    logic                rsta_q;
    logic [DW-1:0]       fifo_mem [RSP_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         count;
    logic [CW-1:0]       used;
    logic                accept;
    logic                rd_acc;
    logic                push;
    logic                pop;

    // Every read in the RAM pipeline already owns a FIFO slot, so pushes can never overflow.
    assign used      = CW'(count) + CW'(s1) + CW'(s2);
    assign req_ready = live & (used < CW'(RSP_DEPTH)) & ~flush;
    assign accept    = req_valid & req_ready;
    assign rd_acc    = accept & ~(|req_we);

    assign ram_ena    = accept;
    assign ram_wea    = accept ? req_we : '0;
    assign ram_addra  = live ? req_addr : '0;
    assign ram_dina   = live ? req_wdata : '0;
    assign ram_regcea = s1;
    assign ram_rsta   = rsta_q;

    assign push      = s2;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];

    // live holds req_ready low for the first cycle after reset release.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            live   <= 1'b0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            rsta_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            live   <= 1'b1;
            rsta_q <= flush;
            if (flush) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                s1 <= rd_acc;
                s2 <= s1;
                if (push) begin
                    fifo_mem[wr_ptr] <= ram_douta;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

`ifdef BRAM_PORTA_STATS_EN
    logic wr_acc;
    logic stall;

    assign wr_acc = accept & (|req_we);
    assign stall  = req_valid & ~req_ready;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            stat_rd_cnt    <= '0;
            stat_wr_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (rd_acc && stat_rd_cnt != 16'hFFFF) begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
            if (wr_acc && stat_wr_cnt != 16'hFFFF) begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
            if (stall && stat_stall_cnt != 16'hFFFF) begin
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_porta_req_ctrl.sv
// tb/tb_bram_porta_req_ctrl.sv - scoreboard bench for bram_porta_req_ctrl with a write-first BRAM port A model
module tb_bram_porta_req_ctrl;

    localparam int NB  = 4;
    localparam int CWD = 8;
    localparam int AW  = 10;
    localparam int DW  = NB * CWD;

    logic            clka = 1'b0;
    logic            rsta_n;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [NB-1:0]   req_we;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   ram_addra;
    logic [DW-1:0]   ram_dina;
    logic [NB-1:0]   ram_wea;
    logic            ram_ena;
    logic            ram_regcea;
    logic            ram_rsta;
    logic [DW-1:0]   ram_douta;
`ifdef BRAM_PORTA_STATS_EN
    logic [15:0]     stat_rd_cnt;
    logic [15:0]     stat_wr_cnt;
    logic [15:0]     stat_stall_cnt;
`endif

    always #5 clka = ~clka;

    bram_porta_req_ctrl #(.NB_COL(NB), .COL_WIDTH(CWD), .ADDR_WIDTH(AW), .RSP_DEPTH(4)) dut (
        .clka(clka), .rsta_n(rsta_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_ena(ram_ena), .ram_regcea(ram_regcea), .ram_rsta(ram_rsta),
        .ram_douta(ram_douta)
`ifdef BRAM_PORTA_STATS_EN
        ,
        .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    // Write-first byte-write RAM with an output register (regcea/rsta).
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] merged;
    logic [DW-1:0] latch_q = '0;
    logic [DW-1:0] dout_q = '0;

    always_comb begin
        merged = mem[ram_addra];
        for (int b = 0; b < NB; b++) begin
            if (ram_wea[b]) merged[b*CWD +: CWD] = ram_dina[b*CWD +: CWD];
        end
    end

    always @(posedge clka) begin
        if (ram_ena) begin
            if (|ram_wea) mem[ram_addra] <= merged;
            latch_q <= merged;
        end
        if (ram_rsta) dout_q <= '0;
        else if (ram_regcea) dout_q <= latch_q;
    end
    assign ram_douta = dout_q;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q [$];
    int acc_q [$];
    int rsp_q [$];
    int rsta_cyc_q [$];
    logic [DW-1:0] last_rsp = '0;
    int n_rd_acc = 0;
    int n_wr_acc = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge clka) cyc <= cyc + 1;

    // Monitor: builds expectations from accepted requests and scores every response handshake.
    always @(negedge clka) begin
        if (!rsta_n) begin
            exp_q.delete();
        end else begin
            if (ram_rsta) rsta_cyc_q.push_back(cyc);
            if (rsp_valid && rsp_ready) begin
                rsp_q.push_back(cyc);
                last_rsp = rsp_rdata;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata);
                end else begin
                    check("rsp_data", rsp_rdata, exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            if (req_valid && req_ready) begin
                if (req_we == '0) begin
                    exp_q.push_back(ref_mem[req_addr]);
                    acc_q.push_back(cyc);
                    n_rd_acc++;
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        if (req_we[b]) ref_mem[req_addr][b*CWD +: CWD] = req_wdata[b*CWD +: CWD];
                    end
                    n_wr_acc++;
                end
            end
        end
    end

    task automatic send(input logic [NB-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        logic hs = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        do begin
            @(negedge clka);
            hs = req_ready;
            @(posedge clka); #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) check("send_timeout", 32'd0, 32'd1);
        req_valid = 1'b0; req_we = '0;
    endtask

    task automatic wait_rsp(input int n, input string name);
        int k = 0;
        while (rsp_q.size() < n && k < 100) begin
            @(posedge clka);
            k++;
        end
        #1;
        if (rsp_q.size() < n) check(name, rsp_q.size(), n);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        rsp_q.delete();
        rsta_cyc_q.delete();
    endtask

    initial begin
        int fc;
        int k;
        rsta_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 4'hF; req_addr = 10'h3; req_wdata = 32'hDEADBEEF;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i);
            ref_mem[i] = DW'(i);
        end

        // Reset: all control outputs low during reset and the first cycle after release.
        repeat (2) @(negedge clka);
        check("reset_outputs", {26'd0, rsp_valid, req_ready, ram_ena, ram_regcea, ram_rsta, |ram_wea}, 32'd0);
        @(posedge clka); #1 rsta_n = 1'b1;
        @(negedge clka);
        check("release_outputs", {26'd0, rsp_valid, req_ready, ram_ena, ram_regcea, ram_rsta, |ram_wea}, 32'd0);
        @(posedge clka); #1 req_valid = 1'b0; req_we = '0;
        @(negedge clka);
        check("ready_after_release", req_ready, 1);
        @(posedge clka); #1 rsp_ready = 1'b1;

        // Write then read: 3-cycle latency.
        clear_logs();
        send(4'hF, 10'h010, 32'hA5A5A5A5);
        send(4'h0, 10'h010, 32'h0);
        wait_rsp(1, "t1_rsp_timeout");
        if (rsp_q.size() > 0 && acc_q.size() > 0) check("t1_latency", rsp_q[0] - acc_q[0], 3);
        check("t1_data", last_rsp, 32'hA5A5A5A5);

        // Byte-masked overwrite.
        @(posedge clka); #1 clear_logs();
        send(4'hF, 10'h020, 32'h11223344);
        send(4'b0101, 10'h020, 32'hFFFFFFFF);
        send(4'h0, 10'h020, 32'h0);
        wait_rsp(1, "t2_rsp_timeout");
        check("t2_data", last_rsp, 32'h11FF33FF);

        // Backpressure: credits stop acceptance at four outstanding reads.
        @(posedge clka); #1 clear_logs(); rsp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(4'h0, AW'(i), 32'h0);
            end
            begin
                k = 0;
                while (acc_q.size() < 4 && k < 50) begin @(posedge clka); k++; end
                repeat (3) @(posedge clka);
                @(negedge clka);
                check("t3_ready_low", req_ready, 0);
                check("t3_accepts", acc_q.size(), 4);
                check("t3_rsp_valid", rsp_valid, 1);
                check("t3_head", rsp_rdata, 32'h0);
                @(posedge clka); #1 rsp_ready = 1'b1;
            end
        join
        wait_rsp(6, "t3_rsp_timeout");
        repeat (5) @(posedge clka); #1;
        check("t3_rsp_count", rsp_q.size(), 6);
        check("t3_last", last_rsp, 32'h5);

        // Full throughput back-to-back reads.
        clear_logs();
        for (int i = 1; i <= 8; i++) send(4'h0, AW'(i), 32'h0);
        wait_rsp(8, "t4_rsp_timeout");
        if (acc_q.size() == 8 && rsp_q.size() == 8) begin
            check("t4_accept_span", acc_q[7] - acc_q[0], 7);
            check("t4_first_latency", rsp_q[0] - acc_q[0], 3);
            check("t4_rsp_span", rsp_q[7] - rsp_q[0], 7);
        end else begin
            check("t4_counts", {acc_q.size(), rsp_q.size()}, {32'd8, 32'd8});
        end

        // Flush discards in-flight reads.
        repeat (3) @(posedge clka); #1 clear_logs();
        send(4'h0, 10'h030, 32'h0);
        send(4'h0, 10'h031, 32'h0);
        flush = 1'b1;
        @(negedge clka);
        fc = cyc;
        check("t5_ready_in_flush", req_ready, 0);
        @(posedge clka); #1 flush = 1'b0;
        @(negedge clka);
        check("t5_ready_after_flush", req_ready, 1);
        repeat (8) @(posedge clka); #1;
        check("t5_no_rsp", rsp_q.size(), 0);
        check("t5_rsta_cycles", rsta_cyc_q.size(), 1);
        if (rsta_cyc_q.size() > 0) check("t5_rsta_when", rsta_cyc_q[0], fc + 1);
        send(4'h0, 10'h010, 32'h0);
        wait_rsp(1, "t5_rsp_timeout");
        check("t5_post_flush_data", last_rsp, 32'hA5A5A5A5);

        // Reset with buffered responses.
        @(posedge clka); #1 clear_logs(); rsp_ready = 1'b0;
        send(4'h0, 10'h002, 32'h0);
        send(4'h0, 10'h003, 32'h0);
        send(4'h0, 10'h004, 32'h0);
        repeat (5) @(posedge clka);
        @(negedge clka);
        check("t6_buffered", rsp_valid, 1);
`ifdef BRAM_PORTA_STATS_EN
        check("t6_stat_rd_before", stat_rd_cnt, n_rd_acc);
        check("t6_stat_wr_before", stat_wr_cnt, n_wr_acc);
`endif
        @(posedge clka); #1 rsta_n = 1'b0;
        @(negedge clka);
        check("t6_in_reset", {rsp_valid, req_ready}, 0);
        @(posedge clka);
        @(posedge clka); #1 rsta_n = 1'b1; rsp_ready = 1'b1;
        @(negedge clka);
        check("t6_release_valid", rsp_valid, 0);
        check("t6_release_ready", req_ready, 0);
`ifdef BRAM_PORTA_STATS_EN
        check("t6_stats_zero", {stat_rd_cnt, stat_wr_cnt}, 0);
        check("t6_stall_zero", stat_stall_cnt, 0);
`endif
        @(posedge clka);
        @(negedge clka);
        check("t6_ready_back", req_ready, 1);
        check("t6_valid_low", rsp_valid, 0);
        repeat (5) @(posedge clka); #1;
        check("t6_no_rsp", rsp_q.size(), 0);
        check("final_exp_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_porta_req_ctrl.md
Name: bram_porta_req_ctrl

Overview:
- Request/response front-end driving port A of the team's byte-write true-dual-port write-first BRAM, configured with its output register (2-cycle read latency, regcea/rsta controlled).
- Accepts a valid/ready request stream (byte-masked writes, reads) and returns in-order read data on a valid/ready response stream.
- Tracks the RAM pipeline and buffers results in a credit-protected response FIFO, so backpressure never loses data.

Parameters:
- NB_COL, 4, byte lanes per word.
- COL_WIDTH, 8, bits per lane.
- ADDR_WIDTH, 10, RAM address width.
- RSP_DEPTH, 4, response FIFO entries; power of two, >=2; >=4 gives full read throughput.

Ports:
- clka  in  1  clock, shared with RAM port A.
- rsta_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards in-flight reads and buffered responses.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_we  in  NB_COL  byte write mask; all-zero means read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  NB_COL*COL_WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  NB_COL*COL_WIDTH  read data.
- ram_addra  out  ADDR_WIDTH  to RAM addra.
- ram_dina  out  NB_COL*COL_WIDTH  to RAM dina.
- ram_wea  out  NB_COL  to RAM wea.
- ram_ena  out  1  to RAM ena.
- ram_regcea  out  1  to RAM regcea.
- ram_rsta  out  1  to RAM rsta.
- ram_douta  in  NB_COL*COL_WIDTH  from RAM douta.

Behaviour:
- Reset: all outputs 0 during reset and in the first cycle after release. FIFO empty, pipeline valids 0, credits 0.
- ram_* request outputs are combinational from req_*:
  - ram_ena = req_valid & req_ready.
  - ram_wea = req_we when ram_ena, else 0.
  - ram_addra = req_addr; ram_dina = req_wdata.
- Pipeline tracking:
  - s1 <= accepted read; s2 <= s1.
  - ram_regcea = s1, so douta is loaded only with read results. Write-first data from writes never reaches the response path.
- FIFO push: when s2 is high, ram_douta is pushed into the FIFO at that edge.
- Latency: read accepted in cycle T -> douta valid in T+2 -> rsp_valid in T+3 (FIFO empty, no stall). Writes produce no response.
- Credits:
  - used = FIFO occupancy + s1 + s2.
  - req_ready = (used < RSP_DEPTH) & !flush, registered-free and independent of req_valid.
  - A FIFO pop frees its credit from the next cycle.
  - Writes are also gated by req_ready.
- Response handshake:
  - rsp_rdata = FIFO head; rsp_valid = FIFO non-empty.
  - Pop on rsp_valid & rsp_ready; simultaneous push and pop is allowed.
  - Ordering: strictly in acceptance order. The FIFO can never overflow, by credits.
- Flush (one cycle):
  - req_ready = 0 that cycle.
  - Next edge: s1, s2 and FIFO cleared; ram_rsta = 1 for the following cycle, clearing douta.
  - No response from any read accepted before flush is ever presented.
  - Writes already issued complete normally.
- Hazards:
  - Read after write to the same address on consecutive cycles returns the new data; the RAM handles this, no forwarding needed.
  - Port B activity is out of scope.
- Reset mid-operation: immediate clear of all state; no partial response is presented after release.

Optional Feature:
- Macro BRAM_PORTA_STATS_EN.
- Defined: adds outputs stat_rd_cnt, stat_wr_cnt and stat_stall_cnt, each 16 bits.
  - stat_rd_cnt / stat_wr_cnt: accepted reads / writes.
  - stat_stall_cnt: cycles with req_valid & !req_ready.
  - All saturate at 16'hFFFF; cleared by rsta_n only (not by flush).
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Write addr 0x010 data 0xA5A5A5A5 we=4'hF, then read 0x010 with rsp_ready=1 -> rsp_valid exactly 3 cycles after the read handshake, rsp_rdata=0xA5A5A5A5.
- Write 0x020 = 0x11223344, then write 0x020 data 0xFFFFFFFF we=4'b0101, read 0x020 -> rsp_rdata=0x11FF33FF.
- rsp_ready=0, issue reads of 0x000..0x005 continuously (RAM preloaded with addr value):
  - req_ready falls after 4 accepts; rsp_valid high with rsp_rdata=0x0.
  - Raise rsp_ready -> responses 0x0,0x1,0x2,0x3,0x4,0x5 in order, no drops.
- Back-to-back reads of 0x001..0x008 with rsp_ready=1 -> req_ready stays 1 and rsp_valid high for 8 consecutive cycles starting 3 cycles after the first accept.
- Two reads accepted, flush pulsed the next cycle:
  - No rsp_valid ever; ram_rsta high one cycle; req_ready returns to 1 the cycle after flush.
  - A subsequent read of 0x010 returns the correct data.
- rsta_n low for 2 cycles while 3 responses are buffered -> rsp_valid=0 and req_ready=0 in the first cycle after release, then req_ready=1; with BRAM_PORTA_STATS_EN all counters read 0.
